// File: rtl/cke_sched_if.sv
// Configuration write port of the clock-enable scheduler.
// Master drives a channel write (index, divisor, enable) with a valid/ready handshake;
// slave answers with ready and a one-cycle error pulse for out-of-range channel writes.
interface cke_sched_if #(
   parameter int N  = 4,
   parameter int DW = 16
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_ch;
   logic [DW-1:0] cfg_div;
   logic          cfg_en;
   logic          cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_en,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_en,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/cke_sched.sv
// Shared base prescaler plus N programmable divider channels producing one-cycle clock-enable strobes.
// Latency: base_cke/cke registered one cycle after the enabled tick cycle; config applies 1 cycle after accept.
// Backpressure: cfg_ready drops for exactly one cycle per accepted write (max one write per 2 cycles).
// Optional feature macro CKE_SCHED_BYPASS_EN: en=1/div=0 channels strobe on every ena-high cycle.
module cke_sched #(
   parameter int T  = 50000000,
   parameter int N  = 4,
   parameter int DW = 16
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         ena,
   cke_sched_if.slave   cfg,
   output logic         base_cke,
   output logic [N-1:0] cke
);

   localparam int              BW      = (T > 1) ? $clog2(T) : 1;
   localparam int              CW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [BW-1:0]   BC_LAST = BW'(T - 1);

   typedef enum logic {S_IDLE, S_APPLY} state_t;

   state_t        state_q;
   logic          ready_q;
   logic          err_q;
   logic [CW-1:0] ch_q;
   logic [DW-1:0] ldiv_q;
   logic          len_q;

   logic [BW-1:0] bc_q, bc_d;
   logic          base_cke_q, base_cke_d;
   logic [N-1:0]  cke_q, cke_d;
   logic [DW-1:0] div_q [N];
   logic [DW-1:0] div_d [N];
   logic [DW-1:0] cc_q  [N];
   logic [DW-1:0] cc_d  [N];
   logic [N-1:0]  en_q, en_d;

   logic          tick;
   logic          apply_ok;

   // Config handshake: accept in IDLE, spend one cycle in APPLY, flag out-of-range channels.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
         ch_q    <= '0;
         ldiv_q  <= '0;
         len_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               err_q <= 1'b0;
               if (cfg.cfg_valid && ready_q) begin
                  ch_q    <= cfg.cfg_ch;
                  ldiv_q  <= cfg.cfg_div;
                  len_q   <= cfg.cfg_en;
                  ready_q <= 1'b0;
                  state_q <= S_APPLY;
               end
            end
            S_APPLY: begin
               err_q   <= !(int'(ch_q) < N);
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Base prescaler, per-channel dividers, and the APPLY override that wins over a same-cycle tick.
   always_comb begin
      bc_d     = bc_q;
      div_d    = div_q;
      cc_d     = cc_q;
      en_d     = en_q;
      cke_d    = '0;
      tick     = ena && (bc_q == '0);
      apply_ok = (state_q == S_APPLY) && (int'(ch_q) < N);

      if (ena) begin
         bc_d = (bc_q == BC_LAST) ? '0 : bc_q + BW'(1);
      end

      for (int i = 0; i < N; i++) begin
         if (tick && en_q[i] && (div_q[i] != '0)) begin
            if (cc_q[i] == div_q[i] - DW'(1)) begin
               cc_d[i]  = '0;
               cke_d[i] = 1'b1;
            end else begin
               cc_d[i] = cc_q[i] + DW'(1);
            end
         end
`ifdef CKE_SCHED_BYPASS_EN
         // Divisor 0 skips the prescaler entirely and follows ena.
         if (en_q[i] && (div_q[i] == '0)) begin
            cke_d[i] = ena;
         end
`endif
         if (apply_ok && (int'(ch_q) == i)) begin
            div_d[i] = ldiv_q;
            en_d[i]  = len_q;
            cc_d[i]  = '0;
            cke_d[i] = 1'b0;
         end
      end

      base_cke_d = tick;
   end

   // Datapath state and registered strobes.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         bc_q       <= '0;
         base_cke_q <= 1'b0;
         cke_q      <= '0;
         div_q      <= '{default: '0};
         cc_q       <= '{default: '0};
         en_q       <= '0;
      end else begin
         bc_q       <= bc_d;
         base_cke_q <= base_cke_d;
         cke_q      <= cke_d;
         div_q      <= div_d;
         cc_q       <= cc_d;
         en_q       <= en_d;
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;
   assign base_cke      = base_cke_q;
   assign cke           = cke_q;

endmodule

// File: tb/tb_cke_sched.sv
// Directed bench for cke_sched with T=4, N=3, DW=8.
// Inputs change and outputs are sampled on the falling edge; cyc counts rising edges since reset release.
// Expected strobe positions are derived by hand from the prescaler/divider arithmetic.
module tb_cke_sched;

   localparam int T  = 4;
   localparam int N  = 3;
   localparam int DW = 8;

`ifdef CKE_SCHED_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk;
   logic         rst_;
   logic         ena;
   logic         base_cke;
   logic [N-1:0] cke;

   int cyc;
   int pass_cnt;
   int total_cnt;

   cke_sched_if #(.N(N), .DW(DW)) cfg_if ();

   cke_sched #(.T(T), .N(N), .DW(DW)) dut (
      .clk      (clk),
      .rst_     (rst_),
      .ena      (ena),
      .cfg      (cfg_if),
      .base_cke (base_cke),
      .cke      (cke)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached (cyc=%0d)", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst_              = 1'b0;
      ena               = 1'b1;
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_ch     = '0;
      cfg_if.cfg_div    = '0;
      cfg_if.cfg_en     = 1'b0;
      step();
      step();
      rst_ = 1'b1;
      cyc  = 0;
   endtask

   // Issue one write while the scheduler is idle; consumes the accept and APPLY edges.
   task automatic do_write(input int ch, input int dv, input bit en);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'(ch);
      cfg_if.cfg_div   = 8'(dv);
      cfg_if.cfg_en    = en;
      step();
      cfg_if.cfg_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [4:0] exp_v;
      rst_             = 1'b0;
      ena              = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_div   = '0;
      cfg_if.cfg_en    = 1'b0;
      step();
      step();
      total_cnt++;
      if (base_cke !== 1'b0) $display("FAIL reset_base_cke got %b want 0", base_cke);
      else pass_cnt++;
      total_cnt++;
      if (cke !== 3'b000) $display("FAIL reset_cke got %b want 000", cke);
      else pass_cnt++;
      total_cnt++;
      if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b want 1", cfg_if.cfg_ready);
      else pass_cnt++;
      total_cnt++;
      if (cfg_if.cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_if.cfg_err);
      else pass_cnt++;
      rst_ = 1'b1;
      cyc  = 0;
      // Free-running base: strobe after edges 1, 5, 9, ...
      for (int k = 0; k < 12; k++) begin
         step();
         exp_v = {(cyc % 4 == 1), 3'b000, 1'b1};
         total_cnt++;
         if ({base_cke, cke, cfg_if.cfg_ready} !== exp_v)
            $display("FAIL base_free cyc=%0d got {base,cke,ready}=%b want %b",
                     cyc, {base_cke, cke, cfg_if.cfg_ready}, exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_divider();
      logic       exp_b;
      logic [2:0] exp_c;
      do_reset();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd1;
      cfg_if.cfg_div   = 8'd3;
      cfg_if.cfg_en    = 1'b1;
      step();
      total_cnt++;
      if (cfg_if.cfg_ready !== 1'b0) $display("FAIL div_ready_low got %b want 0", cfg_if.cfg_ready);
      else pass_cnt++;
      cfg_if.cfg_valid = 1'b0;
      step();
      total_cnt++;
      if (cfg_if.cfg_ready !== 1'b1) $display("FAIL div_ready_back got %b want 1", cfg_if.cfg_ready);
      else pass_cnt++;
      // Applied at edge 2; base ticks at 5, 9, 13 -> channel 1 fires at 13, 25, 37.
      while (cyc < 40) begin
         step();
         exp_b = (cyc % 4 == 1);
         exp_c = (cyc >= 13 && (cyc - 13) % 12 == 0) ? 3'b010 : 3'b000;
         total_cnt++;
         if (base_cke !== exp_b) $display("FAIL div3_base cyc=%0d got %b want %b", cyc, base_cke, exp_b);
         else pass_cnt++;
         total_cnt++;
         if (cke !== exp_c) $display("FAIL div3_cke cyc=%0d got %b want %b", cyc, cke, exp_c);
         else pass_cnt++;
      end
   endtask

   task automatic test_ena_gap();
      logic       exp_b;
      logic [2:0] exp_c;
      do_reset();
      do_write(1, 3, 1'b1);
      // ena low for edges 9..13, exactly where a tick was due; everything shifts by 5.
      while (cyc < 45) begin
         ena = !(cyc >= 8 && cyc <= 12);
         step();
         if (cyc <= 8)       exp_b = (cyc % 4 == 1);
         else if (cyc <= 13) exp_b = 1'b0;
         else                exp_b = (cyc % 4 == 2);
         exp_c = (cyc >= 18 && (cyc - 18) % 12 == 0) ? 3'b010 : 3'b000;
         total_cnt++;
         if (base_cke !== exp_b) $display("FAIL gap_base cyc=%0d got %b want %b", cyc, base_cke, exp_b);
         else pass_cnt++;
         total_cnt++;
         if (cke !== exp_c) $display("FAIL gap_cke cyc=%0d got %b want %b", cyc, cke, exp_c);
         else pass_cnt++;
      end
      ena = 1'b1;
   endtask

   task automatic test_bad_ch();
      do_reset();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd3;
      cfg_if.cfg_div   = 8'd1;
      cfg_if.cfg_en    = 1'b1;
      step();
      total_cnt++;
      if (cfg_if.cfg_err !== 1'b0) $display("FAIL badch_err_accept got %b want 0", cfg_if.cfg_err);
      else pass_cnt++;
      cfg_if.cfg_valid = 1'b0;
      step();
      total_cnt++;
      if (cfg_if.cfg_err !== 1'b1) $display("FAIL badch_err_pulse got %b want 1", cfg_if.cfg_err);
      else pass_cnt++;
      step();
      total_cnt++;
      if (cfg_if.cfg_err !== 1'b0) $display("FAIL badch_err_clear got %b want 0", cfg_if.cfg_err);
      else pass_cnt++;
      while (cyc < 20) begin
         step();
         total_cnt++;
         if (cke !== 3'b000) $display("FAIL badch_cke cyc=%0d got %b want 000", cyc, cke);
         else pass_cnt++;
      end
   endtask

   task automatic test_collision();
      logic [2:0] exp_c;
      do_reset();
      do_write(0, 2, 1'b1);
      // Ch0 div=2 fires at 9; rewrites APPLY on ticks 13 (cc zeroed) and 21 (fire suppressed).
      while (cyc < 30) begin
         if (cyc == 11 || cyc == 19) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_ch    = 2'd0;
            cfg_if.cfg_div   = 8'd2;
            cfg_if.cfg_en    = 1'b1;
         end else begin
            cfg_if.cfg_valid = 1'b0;
         end
         step();
         exp_c = (cyc == 9 || cyc == 29) ? 3'b001 : 3'b000;
         total_cnt++;
         if (cke !== exp_c) $display("FAIL collide_cke cyc=%0d got %b want %b", cyc, cke, exp_c);
         else pass_cnt++;
         if (cyc == 12 || cyc == 20) begin
            total_cnt++;
            if (cfg_if.cfg_ready !== 1'b0)
               $display("FAIL collide_ready cyc=%0d got %b want 0", cyc, cfg_if.cfg_ready);
            else pass_cnt++;
         end
         if (cyc == 13 || cyc == 21) begin
            total_cnt++;
            if (base_cke !== 1'b1) $display("FAIL collide_base cyc=%0d got %b want 1", cyc, base_cke);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int         tch  [4] = '{0, 1, 2, 3};
      int         tdiv [4] = '{1, 2, 4, 7};
      int         idx;
      bit         acc;
      logic       exp_r;
      logic       exp_e;
      logic [2:0] exp_c;
      do_reset();
      idx = 0;
      while (cyc < 26) begin
         if (idx < 4) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_ch    = 2'(tch[idx]);
            cfg_if.cfg_div   = 8'(tdiv[idx]);
            cfg_if.cfg_en    = 1'b1;
         end else begin
            cfg_if.cfg_valid = 1'b0;
         end
         acc = (cfg_if.cfg_valid === 1'b1) && (cfg_if.cfg_ready === 1'b1);
         step();
         if (acc) idx++;
         exp_r = (cyc >= 8) || (cyc % 2 == 0);
         exp_e = (cyc == 8);
         exp_c[0] = (cyc >= 5) && (cyc % 4 == 1);
         exp_c[1] = (cyc >= 9) && ((cyc - 9) % 8 == 0);
         exp_c[2] = (cyc >= 21) && ((cyc - 21) % 16 == 0);
         total_cnt++;
         if (cfg_if.cfg_ready !== exp_r)
            $display("FAIL b2b_ready cyc=%0d got %b want %b", cyc, cfg_if.cfg_ready, exp_r);
         else pass_cnt++;
         total_cnt++;
         if (cfg_if.cfg_err !== exp_e)
            $display("FAIL b2b_err cyc=%0d got %b want %b", cyc, cfg_if.cfg_err, exp_e);
         else pass_cnt++;
         total_cnt++;
         if (cke !== exp_c) $display("FAIL b2b_cke cyc=%0d got %b want %b", cyc, cke, exp_c);
         else pass_cnt++;
      end
      total_cnt++;
      if (idx != 4) $display("FAIL b2b_accepts got %0d want 4", idx);
      else pass_cnt++;
   endtask

   task automatic test_div0_and_reset();
      logic [2:0] exp_c;
      do_reset();
      do_write(2, 0, 1'b1);
      exp_c = BYP ? 3'b100 : 3'b000;
      while (cyc < 4) begin
         step();
         total_cnt++;
         if (cke !== exp_c) $display("FAIL div0_cke cyc=%0d got %b want %b", cyc, cke, exp_c);
         else pass_cnt++;
      end
      // Write accepted on edge 5 so the reset lands mid-handshake while base_cke is high.
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd0;
      cfg_if.cfg_div   = 8'd5;
      cfg_if.cfg_en    = 1'b1;
      step();
      cfg_if.cfg_valid = 1'b0;
      total_cnt++;
      if ({base_cke, cke, cfg_if.cfg_ready} !== {1'b1, exp_c, 1'b0})
         $display("FAIL prerst_state got {base,cke,ready}=%b want %b",
                  {base_cke, cke, cfg_if.cfg_ready}, {1'b1, exp_c, 1'b0});
      else pass_cnt++;
      #1;
      rst_ = 1'b0;
      #1;
      total_cnt++;
      if (base_cke !== 1'b0) $display("FAIL midrst_base got %b want 0", base_cke);
      else pass_cnt++;
      total_cnt++;
      if (cke !== 3'b000) $display("FAIL midrst_cke got %b want 000", cke);
      else pass_cnt++;
      total_cnt++;
      if (cfg_if.cfg_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", cfg_if.cfg_ready);
      else pass_cnt++;
      total_cnt++;
      if (cfg_if.cfg_err !== 1'b0) $display("FAIL midrst_err got %b want 0", cfg_if.cfg_err);
      else pass_cnt++;
      @(negedge clk);
      rst_ = 1'b1;
      cyc  = 0;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      cyc       = 0;
      test_reset();
      test_divider();
      test_ena_gap();
      test_bad_ch();
      test_collision();
      test_back_to_back();
      test_div0_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
